otter_cu_fsm: RTL and testbench
===============================

// Module: otter_cu_fsm
// PURPOSE
//  Multicycle control-unit FSM for the OTTER RV32I core. Sequences fetch, execute,
//  load writeback and interrupt entry, and emits the strobes that gate the PC,
//  register file, memory and CSR file. The decoder owns the datapath mux selects,
//  including ALU_SRCB. This FSM only decides *when* state-changing writes occur.
// PARAMETERS
//  INIT_CYCLES  1  cycles spent in INIT after reset release before first FETCH (>=1)
// PORTS
//  CLK        in   1  core clock, rising edge
//  RST        in   1  asynchronous reset, active-high
//  OPCODE     in   7  IR[6:0], stable from EXEC onward
//  FUNC3      in   3  IR[14:12]
//  INTR       in   1  interrupt request, already masked by MIE externally
//  MEM_READY  in   1  memory ready (port exists only with OTTER_MEM_WAIT_EN)
//  PC_WRITE   out  1  load PC with next-PC mux output at end of cycle
//  REG_WRITE  out  1  register-file write enable
//  MEM_RDEN1  out  1  instruction-port read enable
//  MEM_RDEN2  out  1  data-port read enable
//  MEM_WE2    out  1  data-port write enable
//  CSR_WE     out  1  CSR file write enable
//  INT_TAKEN  out  1  interrupt entry: save mepc/mcause, clear MIE, PC<=mtvec
//  MRET_EXEC  out  1  mret: restore MIE, PC<=mepc
//  DBG_STATE  out  3  current state: INIT=0 FETCH=1 EXEC=2 WB=3 INTR=4
// BEHAVIOUR
//  - States INIT, FETCH, EXEC, WB, INTR. State and the INIT counter are registers.
//    All strobe outputs are combinational from state, OPCODE and FUNC3.
//  - RST=1 at any time forces INIT immediately; all strobes go 0 that same cycle.
//    DBG_STATE=0. The in-flight instruction is abandoned with no partial write.
//  - INIT: all strobes 0. Counts INIT_CYCLES cycles, then moves to FETCH.
//  - FETCH: MEM_RDEN1=1. Next state is EXEC.
//  - EXEC, decoded from OPCODE:
//      LOAD 0000011: MEM_RDEN2=1, PC_WRITE=0. Next state is WB. INTR is ignored here.
//      STORE 0100011: MEM_WE2=1, PC_WRITE=1.
//      OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111,
//        JALR 1100111: REG_WRITE=1, PC_WRITE=1.
//      BRANCH 1100011: PC_WRITE=1. The decoder selects the taken or fall-through PC.
//      SYSTEM 1110011, FUNC3=001 (csrrw): CSR_WE=1, REG_WRITE=1, PC_WRITE=1.
//      SYSTEM 1110011, FUNC3=000 (mret): MRET_EXEC=1, PC_WRITE=1.
//      Any other OPCODE/FUNC3 is a NOP: PC_WRITE=1 only.
//      For every non-load opcode, the next state is INTR if INTR=1, else FETCH.
//  - WB: REG_WRITE=1, PC_WRITE=1. Next state is INTR if INTR=1, else FETCH.
//  - INTR: INT_TAKEN=1, PC_WRITE=1. Next state is FETCH. INTR is not re-sampled.
//  - INTR is sampled only on the final cycle of an instruction.
//    mret followed by INTR=1 enters INTR on the next cycle.
//  - Latency: 2 cycles per instruction, 3 for loads, +1 when an interrupt is taken.
//  - At most one of MEM_WE2 / MEM_RDEN2 / CSR_WE / INT_TAKEN / MRET_EXEC is high
//    in any cycle, with the single exception of CSR_WE together with REG_WRITE.
//  - Unreachable state encodings (5..7) have all strobes 0 and go to INIT next cycle.
// CONFIGURATION
//  OTTER_MEM_WAIT_EN defined: the MEM_READY input exists.
//    FETCH holds MEM_RDEN1=1 and stays in FETCH until MEM_READY=1.
//    EXEC LOAD holds MEM_RDEN2=1 and stays in EXEC until MEM_READY=1, then goes to WB.
//    EXEC STORE holds MEM_WE2=1 with PC_WRITE=0 until MEM_READY=1. In that cycle
//      PC_WRITE=1 and normal sequencing resumes.
//    While waiting, INTR is not sampled and no other strobe is asserted.
//  OTTER_MEM_WAIT_EN undefined: there is no MEM_READY port. Behaviour is identical
//    to MEM_READY tied to 1 (fixed single-cycle memory).
// TESTING
//  1. RST=1 asserted mid-EXEC of addi -> REG_WRITE and PC_WRITE drop to 0 in the same
//     cycle, DBG_STATE=0. Release RST with INIT_CYCLES=1 -> 1 cycle in INIT, then
//     FETCH with MEM_RDEN1=1.
//  2. OPCODE=0010011, INTR=0 -> FETCH(MEM_RDEN1=1), then EXEC(REG_WRITE=1, PC_WRITE=1),
//     then FETCH. The period is exactly 2 cycles.
//  3. OPCODE=0000011 -> EXEC has MEM_RDEN2=1, REG_WRITE=0, PC_WRITE=0. WB has
//     REG_WRITE=1, PC_WRITE=1. INTR=1 during EXEC is deferred: WB goes to INTR.
//  4. OPCODE=0100011 with INTR=1 in EXEC -> MEM_WE2=1, PC_WRITE=1, then INTR state
//     with INT_TAKEN=1, PC_WRITE=1, then FETCH.
//  5. OPCODE=1110011, FUNC3=001 -> CSR_WE=1, REG_WRITE=1, PC_WRITE=1.
//     FUNC3=000 -> MRET_EXEC=1, PC_WRITE=1, REG_WRITE=0.
//     FUNC3=010 -> PC_WRITE=1 only.
//  6. With OTTER_MEM_WAIT_EN: MEM_READY=0 for 3 cycles in FETCH -> MEM_RDEN1=1 for 4
//     cycles, DBG_STATE=1 throughout, and no PC_WRITE until EXEC.

Source files
------------

// File: rtl/otter_cu_fsm.sv
// Multicycle control-unit FSM for the OTTER RV32I core: sequences fetch/exec/writeback/interrupt.
// Optional memory wait-states are enabled by defining OTTER_MEM_WAIT_EN (adds the MEM_READY port).
module otter_cu_fsm #(
  parameter int unsigned INIT_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] OPCODE,
  input  logic [2:0] FUNC3,
  input  logic       INTR,
`ifdef OTTER_MEM_WAIT_EN
  input  logic       MEM_READY,
`endif
  output logic       PC_WRITE,
  output logic       REG_WRITE,
  output logic       MEM_RDEN1,
  output logic       MEM_RDEN2,
  output logic       MEM_WE2,
  output logic       CSR_WE,
  output logic       INT_TAKEN,
  output logic       MRET_EXEC,
  output logic [2:0] DBG_STATE
);

  localparam int unsigned CntW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [CntW-1:0] InitLast = CntW'(INIT_CYCLES - 1);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [2:0] {
    StInit  = 3'd0,
    StFetch = 3'd1,
    StExec  = 3'd2,
    StWb    = 3'd3,
    StIntr  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_rdy;
  state_t          after_instr;

`ifdef OTTER_MEM_WAIT_EN
  assign mem_rdy = MEM_READY;
`else
  assign mem_rdy = 1'b1;
`endif

  // Interrupts are only taken at an instruction boundary.
  assign after_instr = INTR ? StIntr : StFetch;
  assign DBG_STATE   = state_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = StInit;
    cnt_d     = '0;
    PC_WRITE  = 1'b0;
    REG_WRITE = 1'b0;
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    CSR_WE    = 1'b0;
    INT_TAKEN = 1'b0;
    MRET_EXEC = 1'b0;
    case (state_q)
      StInit: begin
        if (cnt_q == InitLast) begin
          state_d = StFetch;
        end else begin
          state_d = StInit;
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      StFetch: begin
        MEM_RDEN1 = 1'b1;
        state_d   = mem_rdy ? StExec : StFetch;
      end
      StExec: begin
        state_d = after_instr;
        case (OPCODE)
          OpLoad: begin
            MEM_RDEN2 = 1'b1;
            state_d   = mem_rdy ? StWb : StExec;
          end
          OpStore: begin
            MEM_WE2  = 1'b1;
            PC_WRITE = mem_rdy;
            state_d  = mem_rdy ? after_instr : StExec;
          end
          OpReg, OpImm, OpLui, OpAuipc, OpJal, OpJalr: begin
            REG_WRITE = 1'b1;
            PC_WRITE  = 1'b1;
          end
          OpSystem: begin
            PC_WRITE = 1'b1;
            if (FUNC3 == 3'b001) begin
              CSR_WE    = 1'b1;
              REG_WRITE = 1'b1;
            end else if (FUNC3 == 3'b000) begin
              MRET_EXEC = 1'b1;
            end
          end
          // Branch and unknown opcodes only advance the PC.
          OpBranch: PC_WRITE = 1'b1;
          default:  PC_WRITE = 1'b1;
        endcase
      end
      StWb: begin
        REG_WRITE = 1'b1;
        PC_WRITE  = 1'b1;
        state_d   = after_instr;
      end
      StIntr: begin
        INT_TAKEN = 1'b1;
        PC_WRITE  = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StInit;
    endcase
  end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Self-checking bench for otter_cu_fsm: directed literal checks, then random instruction
// streams against an instruction-level behavioural model.
module tb_otter_cu_fsm;

  localparam int unsigned InitN = 1;

  logic       CLK = 1'b0;
  logic       RST;
  logic [6:0] OPCODE;
  logic [2:0] FUNC3;
  logic       INTR;
  logic       MEM_READY;
  logic       PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2;
  logic       CSR_WE, INT_TAKEN, MRET_EXEC;
  logic [2:0] DBG_STATE;

  always #5 CLK = ~CLK;

  otter_cu_fsm #(.INIT_CYCLES(InitN)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .OPCODE    (OPCODE),
    .FUNC3     (FUNC3),
    .INTR      (INTR),
`ifdef OTTER_MEM_WAIT_EN
    .MEM_READY (MEM_READY),
`endif
    .PC_WRITE  (PC_WRITE),
    .REG_WRITE (REG_WRITE),
    .MEM_RDEN1 (MEM_RDEN1),
    .MEM_RDEN2 (MEM_RDEN2),
    .MEM_WE2   (MEM_WE2),
    .CSR_WE    (CSR_WE),
    .INT_TAKEN (INT_TAKEN),
    .MRET_EXEC (MRET_EXEC),
    .DBG_STATE (DBG_STATE)
  );

  // {pc, reg, rden1, rden2, we2, csr, int, mret}
  wire [7:0] act = {PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE, INT_TAKEN,
                    MRET_EXEC};

  int errors = 0;
  int checks = 0;

  // Model: where we are inside the current instruction, numbered like DBG_STATE.
  int m_ph;
  int m_init_left;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_out(input int ph, input logic [6:0] op,
                                           input logic [2:0] f3, input logic rdy);
    logic is_alu;
    is_alu = op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                        7'b1100111};
    case (ph)
      1: return 8'b0010_0000;
      2: begin
        if (op == 7'b0000011) return 8'b0001_0000;
        if (op == 7'b0100011) return {rdy, 7'b000_1000};
        if (is_alu) return 8'b1100_0000;
        if (op == 7'b1110011 && f3 == 3'b001) return 8'b1100_0100;
        if (op == 7'b1110011 && f3 == 3'b000) return 8'b1000_0001;
        return 8'b1000_0000;
      end
      3: return 8'b1100_0000;
      4: return 8'b1000_0010;
      default: return 8'b0000_0000;
    endcase
  endfunction

  task automatic model_reset();
    m_ph        = 0;
    m_init_left = InitN;
  endtask

  task automatic model_step();
    logic rdy;
    logic done;
    rdy = MEM_READY;
    if (RST) begin
      model_reset();
      return;
    end
    case (m_ph)
      0: begin
        if (m_init_left <= 1) m_ph = 1;
        else m_init_left--;
      end
      1: if (rdy) m_ph = 2;
      2: begin
        if (OPCODE == 7'b0000011) begin
          if (rdy) m_ph = 3;
        end else begin
          done = (OPCODE != 7'b0100011) || rdy;
          if (done) m_ph = INTR ? 4 : 1;
        end
      end
      3: m_ph = INTR ? 4 : 1;
      default: m_ph = 1;
    endcase
  endtask

  task automatic mcheck();
    chk("model_strobes", {24'd0, act}, {24'd0, model_out(m_ph, OPCODE, FUNC3, MEM_READY)});
    chk("model_state", {29'd0, DBG_STATE}, m_ph);
    chk("exclusive", {31'd0, $countones(act[4:0]) <= 1}, 32'd1);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic at_neg(input string name, input logic [7:0] exp_act, input logic [2:0] exp_st);
    @(negedge CLK);
    chk(name, {24'd0, act}, {24'd0, exp_act});
    chk({name, "_st"}, {29'd0, DBG_STATE}, {29'd0, exp_st});
    mcheck();
  endtask

  logic [6:0] ops [12] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
                           7'h73, 7'h73, 7'h0f};

  initial begin
    RST = 1'b1; OPCODE = 7'h13; FUNC3 = 3'd0; INTR = 1'b0; MEM_READY = 1'b1;
    model_reset();
    repeat (2) tick();
    at_neg("reset_state", 8'h00, 3'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
    at_neg("init", 8'h00, 3'd0);
    tick();
    at_neg("fetch0", 8'b0010_0000, 3'd1);
    tick();
    at_neg("addi_exec", 8'b1100_0000, 3'd2);
    // Reset mid-EXEC must kill the strobes immediately.
    RST = 1'b1;
    #1;
    chk("rst_async_act", {24'd0, act}, 32'd0);
    chk("rst_async_st", {29'd0, DBG_STATE}, 32'd0);
    model_reset();
    tick();
    RST = 1'b0;
    model_reset();
    at_neg("init_after_rst", 8'h00, 3'd0);
    tick();
    at_neg("fetch_after_rst", 8'b0010_0000, 3'd1);
    tick();
    at_neg("addi_exec2", 8'b1100_0000, 3'd2);
    tick();
    at_neg("addi_period", 8'b0010_0000, 3'd1);
    OPCODE = 7'b0000011;
    tick();
    at_neg("load_exec", 8'b0001_0000, 3'd2);
    INTR = 1'b1;
    tick();
    at_neg("load_wb", 8'b1100_0000, 3'd3);
    tick();
    at_neg("load_intr", 8'b1000_0010, 3'd4);
    INTR = 1'b0;
    OPCODE = 7'b0100011;
    tick();
    at_neg("fetch_store", 8'b0010_0000, 3'd1);
    tick();
    at_neg("store_exec", 8'b1000_1000, 3'd2);
    INTR = 1'b1;
    tick();
    at_neg("store_intr", 8'b1000_0010, 3'd4);
    INTR = 1'b0;
    OPCODE = 7'b1110011; FUNC3 = 3'b001;
    tick();
    at_neg("fetch_csr", 8'b0010_0000, 3'd1);
    tick();
    at_neg("csrrw", 8'b1100_0100, 3'd2);
    FUNC3 = 3'b000;
    tick();
    tick();
    at_neg("mret", 8'b1000_0001, 3'd2);
    INTR = 1'b1;
    tick();
    at_neg("mret_intr", 8'b1000_0010, 3'd4);
    INTR = 1'b0;
    FUNC3 = 3'b010;
    tick();
    tick();
    at_neg("sys_nop", 8'b1000_0000, 3'd2);
    tick();
`ifdef OTTER_MEM_WAIT_EN
    for (int i = 0; i < 4; i++) begin
      MEM_READY = (i == 3);
      #1;
      chk("fetch_wait", {24'd0, act}, {24'd0, 8'b0010_0000});
      chk("fetch_wait_st", {29'd0, DBG_STATE}, 32'd1);
      mcheck();
      tick();
      if (i < 3) @(negedge CLK);
    end
    @(negedge CLK);
    chk("wait_exec_st", {29'd0, DBG_STATE}, 32'd2);
    MEM_READY = 1'b1;
    tick();
`endif

    // Random instruction streams, including occasional asynchronous reset.
    for (int c = 0; c < 3000; c++) begin
      INTR = ($urandom_range(0, 3) == 0);
`ifdef OTTER_MEM_WAIT_EN
      MEM_READY = ($urandom_range(0, 2) != 0);
`endif
      if (m_ph <= 1) begin
        int k;
        k = $urandom_range(0, 12);
        OPCODE = (k == 12) ? 7'($urandom) : ops[k];
        FUNC3  = 3'($urandom_range(0, 3));
      end
      if (RST) begin
        RST = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        RST = 1'b1;
        #1;
        chk("rand_rst_act", {24'd0, act}, 32'd0);
        chk("rand_rst_st", {29'd0, DBG_STATE}, 32'd0);
        model_reset();
      end
      @(negedge CLK);
      mcheck();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
